mul_reservation_station: RTL and testbench
==========================================

Name: mul_reservation_station

Overview:
- Reservation station directly upstream of the pipelined 32x32 multiplier in the superscalar out-of-order core.
- Holds dispatched multiply instructions until both source operands are available. Snoops the common data bus (CDB) for pending operand tags.
- Issues at most one ready instruction per cycle into the multiplier's A/B/dst_tag/dst/wr_en inputs.
- The multiplier has no stall, so an issued instruction leaves the station permanently.

Parameters:
- DEPTH, 4, number of station entries (2..8).
- TAG_W, 5, width of rename/ROB tags.
- DATA_W, 32, operand width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; all state is cleared while low.
- flush  input  1  synchronous clear of all entries and the issue register (mispredict recovery).
- disp_valid  input  1  dispatch request this cycle.
- disp_vj  input  DATA_W  operand j value; meaningful when disp_rj=1.
- disp_qj  input  TAG_W  producer tag for operand j; meaningful when disp_rj=0.
- disp_rj  input  1  operand j ready.
- disp_vk  input  DATA_W  operand k value.
- disp_qk  input  TAG_W  producer tag for operand k.
- disp_rk  input  1  operand k ready.
- disp_dst_tag  input  TAG_W  destination tag.
- disp_dst  input  5  architectural destination register.
- disp_wr_en  input  1  register write enable of the instruction.
- cdb_valid  input  1  CDB broadcast valid.
- cdb_tag  input  TAG_W  broadcast tag.
- cdb_data  input  DATA_W  broadcast value.
- full  output  1  all DEPTH entries occupied; dispatch must not be presented.
- mul_A  output  DATA_W  to multiplier A.
- mul_B  output  DATA_W  to multiplier B.
- mul_dst_tag  output  TAG_W  to multiplier dst_tag.
- mul_dst  output  5  to multiplier dst.
- mul_wr_en  output  1  to multiplier wr_en; 1 only for an issued instruction whose wr_en=1.
- issue_valid  output  1  an instruction was issued into the multiplier this cycle.

Behaviour:
- Entry fields: busy, vj, qj, rj, vk, qk, rk, dst_tag, dst, wr_en.
- Reset (reset=0, asynchronous) or flush=1 at a clock edge:
  - all busy=0;
  - issue_valid=0, mul_A=0, mul_B=0, mul_dst_tag=0, mul_dst=0, mul_wr_en=0;
  - full=0.
  - flush has priority over dispatch, CDB capture and issue in the same cycle.
- full = (count of busy entries == DEPTH). It is combinational from current state only; an issue in the same cycle does not unblock dispatch.
- Dispatch (disp_valid=1, full=0): write the lowest-index free entry and set busy=1.
  - disp_valid while full=1 is ignored; no entry changes.
- Dispatch-cycle CDB bypass: if cdb_valid=1 and an operand has r=0 and q==cdb_tag, the entry stores cdb_data with r=1 at that edge.
- CDB capture: each edge with cdb_valid=1, every busy entry operand with r=0 and q==cdb_tag loads cdb_data and sets r=1.
  - j and k are checked independently, so both can capture in the same cycle.
- Issue selection: uses entry state before the edge. It picks the lowest-index entry with busy=1, rj=1 and rk=1.
  - An operand captured from the CDB at edge N therefore makes its entry issuable at edge N+1 at the earliest.
- Issue: at the edge, the issue registers load the selected entry's vj, vk, dst_tag, dst, wr_en and issue_valid=1. That entry's busy clears at the same edge.
  - With no eligible entry: issue_valid=0, mul_wr_en=0, all other mul_* outputs = 0. This sends a bubble down the multiplier.
- The freed entry is reusable for dispatch from the next cycle.
- Minimum latency: dispatch with both operands ready at edge N, entry issued at edge N+1, multiplier inputs valid during the cycle after N+1.
- Simultaneous dispatch and issue in the same cycle: legal when full=0. The issued entry and the newly allocated entry are always different indices.
- Tags are never compared for entries with busy=0.
- TAG_W value 0 has no special meaning; readiness is carried only by the r bits.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release with no dispatch -> full=0, issue_valid=0, mul_wr_en=0, all mul_* outputs 0.
- Ready dispatch: dispatch vj=7, vk=6, rj=rk=1, dst_tag=3, dst=9, wr_en=1 at edge N -> at edge N+1 mul_A=7, mul_B=6, mul_dst_tag=3, mul_dst=9, mul_wr_en=1, issue_valid=1; next cycle issue_valid=0.
- CDB wakeup: dispatch qj=5, rj=0, vk=4, rk=1; two cycles later cdb_valid=1, cdb_tag=5, cdb_data=0x10 -> issue one edge after the capture with mul_A=0x10, mul_B=4. A broadcast of tag 6 instead -> no issue.
- Same-cycle bypass and full: dispatch qj=2, rj=0 while cdb_valid=1, cdb_tag=2, cdb_data=11 -> issues next edge with mul_A=11. Then fill 4 non-ready entries -> full=1, and a 5th dispatch is ignored (not issued after all wakeups).
- Priority: entries 0 and 2 both become ready on the same CDB tag -> entry 0 issues first, entry 2 on the following edge.
- Flush / async reset mid-operation: with 3 busy entries, flush=1 for one cycle -> full=0 and no issues afterwards. Asserting reset=0 between clock edges -> issue_valid and mul_wr_en drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mul_reservation_station.sv
// Reservation station feeding the pipelined 32x32 multiplier.
// Holds dispatched multiplies until both operands are ready, snoops the CDB
// for pending tags, and issues at most one ready entry per cycle.
module mul_reservation_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              disp_valid,
  input  logic [DATA_W-1:0] disp_vj,
  input  logic [TAG_W-1:0]  disp_qj,
  input  logic              disp_rj,
  input  logic [DATA_W-1:0] disp_vk,
  input  logic [TAG_W-1:0]  disp_qk,
  input  logic              disp_rk,
  input  logic [TAG_W-1:0]  disp_dst_tag,
  input  logic [4:0]        disp_dst,
  input  logic              disp_wr_en,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              full,
  output logic [DATA_W-1:0] mul_A,
  output logic [DATA_W-1:0] mul_B,
  output logic [TAG_W-1:0]  mul_dst_tag,
  output logic [4:0]        mul_dst,
  output logic              mul_wr_en,
  output logic              issue_valid
);

  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  r_rj;
  logic [DEPTH-1:0]  r_rk;
  logic [DEPTH-1:0]  r_wr_en;
  logic [DATA_W-1:0] r_vj     [DEPTH];
  logic [DATA_W-1:0] r_vk     [DEPTH];
  logic [TAG_W-1:0]  r_qj     [DEPTH];
  logic [TAG_W-1:0]  r_qk     [DEPTH];
  logic [TAG_W-1:0]  r_dst_tag[DEPTH];
  logic [4:0]        r_dst    [DEPTH];

  logic              r_iss_valid;
  logic [DATA_W-1:0] r_mul_A;
  logic [DATA_W-1:0] r_mul_B;
  logic [TAG_W-1:0]  r_mul_tag;
  logic [4:0]        r_mul_dst;
  logic              r_mul_we;

  logic              w_full;
  logic              w_disp_go;
  logic [DEPTH-1:0]  w_alloc_oh;
  logic [DEPTH-1:0]  w_iss_oh;
  logic              w_alloc_found;
  logic              w_iss_found;
  logic [DATA_W-1:0] w_iss_A;
  logic [DATA_W-1:0] w_iss_B;
  logic [TAG_W-1:0]  w_iss_tag;
  logic [4:0]        w_iss_dst;
  logic              w_iss_we;
  logic              w_byp_j;
  logic              w_byp_k;

  assign w_full    = &r_busy;
  assign w_disp_go = disp_valid & ~w_full;
  // Same-cycle CDB bypass for an operand arriving with dispatch.
  assign w_byp_j   = cdb_valid & ~disp_rj & (disp_qj == cdb_tag);
  assign w_byp_k   = cdb_valid & ~disp_rk & (disp_qk == cdb_tag);

  // Priority pick: lowest free entry for allocation, lowest ready entry for issue,
  // both one-hot; the issue mux ORs the selected entry's fields together.
  always_comb begin
    w_alloc_oh    = '0;
    w_iss_oh      = '0;
    w_alloc_found = 1'b0;
    w_iss_found   = 1'b0;
    w_iss_A       = '0;
    w_iss_B       = '0;
    w_iss_tag     = '0;
    w_iss_dst     = '0;
    w_iss_we      = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!r_busy[i] && !w_alloc_found) begin
        w_alloc_oh[i] = 1'b1;
        w_alloc_found = 1'b1;
      end
      if (r_busy[i] && r_rj[i] && r_rk[i] && !w_iss_found) begin
        w_iss_oh[i] = 1'b1;
        w_iss_found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_iss_A   = w_iss_A   | ({DATA_W{w_iss_oh[i]}} & r_vj[i]);
      w_iss_B   = w_iss_B   | ({DATA_W{w_iss_oh[i]}} & r_vk[i]);
      w_iss_tag = w_iss_tag | ({TAG_W{w_iss_oh[i]}}  & r_dst_tag[i]);
      w_iss_dst = w_iss_dst | ({5{w_iss_oh[i]}}      & r_dst[i]);
      w_iss_we  = w_iss_we  | (w_iss_oh[i] & r_wr_en[i]);
    end
  end

  // Entry state: issue frees, dispatch allocates (with bypass), busy entries capture CDB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy  <= '0;
      r_rj    <= '0;
      r_rk    <= '0;
      r_wr_en <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_vj[i]      <= '0;
        r_vk[i]      <= '0;
        r_qj[i]      <= '0;
        r_qk[i]      <= '0;
        r_dst_tag[i] <= '0;
        r_dst[i]     <= '0;
      end
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_iss_oh[i]) begin
          r_busy[i] <= 1'b0;
        end else if (w_disp_go && w_alloc_oh[i]) begin
          r_busy[i]    <= 1'b1;
          r_rj[i]      <= disp_rj | w_byp_j;
          r_rk[i]      <= disp_rk | w_byp_k;
          r_vj[i]      <= w_byp_j ? cdb_data : disp_vj;
          r_vk[i]      <= w_byp_k ? cdb_data : disp_vk;
          r_qj[i]      <= disp_qj;
          r_qk[i]      <= disp_qk;
          r_dst_tag[i] <= disp_dst_tag;
          r_dst[i]     <= disp_dst;
          r_wr_en[i]   <= disp_wr_en;
        end else if (r_busy[i] && cdb_valid) begin
          if (!r_rj[i] && (r_qj[i] == cdb_tag)) begin
            r_vj[i] <= cdb_data;
            r_rj[i] <= 1'b1;
          end
          if (!r_rk[i] && (r_qk[i] == cdb_tag)) begin
            r_vk[i] <= cdb_data;
            r_rk[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Issue register: loads the selected entry, or a zero bubble when nothing is ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iss_valid <= 1'b0;
      r_mul_A     <= '0;
      r_mul_B     <= '0;
      r_mul_tag   <= '0;
      r_mul_dst   <= '0;
      r_mul_we    <= 1'b0;
    end else if (flush) begin
      r_iss_valid <= 1'b0;
      r_mul_A     <= '0;
      r_mul_B     <= '0;
      r_mul_tag   <= '0;
      r_mul_dst   <= '0;
      r_mul_we    <= 1'b0;
    end else begin
      r_iss_valid <= w_iss_found;
      r_mul_A     <= w_iss_A;
      r_mul_B     <= w_iss_B;
      r_mul_tag   <= w_iss_tag;
      r_mul_dst   <= w_iss_dst;
      r_mul_we    <= w_iss_we;
    end
  end

  assign full        = w_full;
  assign issue_valid = r_iss_valid;
  assign mul_A       = r_mul_A;
  assign mul_B       = r_mul_B;
  assign mul_dst_tag = r_mul_tag;
  assign mul_dst     = r_mul_dst;
  assign mul_wr_en   = r_mul_we;

endmodule

// File: tb/tb_mul_reservation_station.sv
// Self-checking bench for mul_reservation_station: a table of directed
// vectors, hand-written multi-cycle sequences and a random run, all checked
// against a behavioural model of the station kept here.
module tb_mul_reservation_station;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        disp_valid;
  logic [31:0] disp_vj;
  logic [4:0]  disp_qj;
  logic        disp_rj;
  logic [31:0] disp_vk;
  logic [4:0]  disp_qk;
  logic        disp_rk;
  logic [4:0]  disp_dst_tag;
  logic [4:0]  disp_dst;
  logic        disp_wr_en;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        full;
  logic [31:0] mul_A;
  logic [31:0] mul_B;
  logic [4:0]  mul_dst_tag;
  logic [4:0]  mul_dst;
  logic        mul_wr_en;
  logic        issue_valid;

  mul_reservation_station #(.DEPTH(D), .TAG_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_vj(disp_vj), .disp_qj(disp_qj), .disp_rj(disp_rj),
    .disp_vk(disp_vk), .disp_qk(disp_qk), .disp_rk(disp_rk),
    .disp_dst_tag(disp_dst_tag), .disp_dst(disp_dst), .disp_wr_en(disp_wr_en),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .full(full), .mul_A(mul_A), .mul_B(mul_B), .mul_dst_tag(mul_dst_tag),
    .mul_dst(mul_dst), .mul_wr_en(mul_wr_en), .issue_valid(issue_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: one record per slot, plus the multiplier-side outputs.
  typedef struct {
    bit          busy;
    logic [31:0] vj, vk;
    logic [4:0]  qj, qk, tag, dst;
    bit          rj, rk, we;
  } slot_t;
  slot_t       m_s [D];
  bit          m_iv, m_we, m_full;
  logic [31:0] m_A, m_B;
  logic [4:0]  m_tag, m_dst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear_out();
    m_iv = 0; m_we = 0; m_A = 0; m_B = 0; m_tag = 0; m_dst = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_s[i].busy = 0;
    model_clear_out();
    m_full = 0;
  endtask

  // One clock edge of the station, from the inputs currently driven.
  task automatic model_step();
    int sel, alloc, cnt;
    cnt = 0;
    for (int i = 0; i < D; i++) cnt += int'(m_s[i].busy);
    if (flush) begin
      model_reset();
      return;
    end
    sel = -1;
    for (int i = 0; i < D; i++)
      if (sel < 0 && m_s[i].busy && m_s[i].rj && m_s[i].rk) sel = i;
    alloc = -1;
    if (disp_valid && cnt < D)
      for (int i = 0; i < D; i++)
        if (alloc < 0 && !m_s[i].busy) alloc = i;
    if (cdb_valid)
      for (int i = 0; i < D; i++)
        if (m_s[i].busy) begin
          if (!m_s[i].rj && m_s[i].qj == cdb_tag) begin m_s[i].vj = cdb_data; m_s[i].rj = 1; end
          if (!m_s[i].rk && m_s[i].qk == cdb_tag) begin m_s[i].vk = cdb_data; m_s[i].rk = 1; end
        end
    if (sel >= 0) begin
      m_iv = 1; m_A = m_s[sel].vj; m_B = m_s[sel].vk;
      m_tag = m_s[sel].tag; m_dst = m_s[sel].dst; m_we = m_s[sel].we;
      m_s[sel].busy = 0;
    end else begin
      model_clear_out();
    end
    if (alloc >= 0) begin
      m_s[alloc].busy = 1;
      m_s[alloc].qj = disp_qj; m_s[alloc].qk = disp_qk;
      m_s[alloc].tag = disp_dst_tag; m_s[alloc].dst = disp_dst; m_s[alloc].we = disp_wr_en;
      m_s[alloc].rj = disp_rj; m_s[alloc].vj = disp_vj;
      m_s[alloc].rk = disp_rk; m_s[alloc].vk = disp_vk;
      if (cdb_valid && !disp_rj && disp_qj == cdb_tag) begin m_s[alloc].rj = 1; m_s[alloc].vj = cdb_data; end
      if (cdb_valid && !disp_rk && disp_qk == cdb_tag) begin m_s[alloc].rk = 1; m_s[alloc].vk = cdb_data; end
    end
    cnt = 0;
    for (int i = 0; i < D; i++) cnt += int'(m_s[i].busy);
    m_full = (cnt == D);
  endtask

  task automatic idle();
    disp_valid = 0; cdb_valid = 0; flush = 0;
    disp_vj = 0; disp_qj = 0; disp_rj = 0; disp_vk = 0; disp_qk = 0; disp_rk = 0;
    disp_dst_tag = 0; disp_dst = 0; disp_wr_en = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic disp(input logic [31:0] vj, input logic [4:0] qj, input logic rj,
                      input logic [31:0] vk, input logic [4:0] qk, input logic rk,
                      input logic [4:0] tag, input logic [4:0] dst, input logic we);
    disp_valid = 1; disp_vj = vj; disp_qj = qj; disp_rj = rj;
    disp_vk = vk; disp_qk = qk; disp_rk = rk;
    disp_dst_tag = tag; disp_dst = dst; disp_wr_en = we;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] data);
    cdb_valid = 1; cdb_tag = tag; cdb_data = data;
  endtask

  // Apply current inputs for one edge and compare the DUT with the model.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_issue_valid", {31'd0, issue_valid}, {31'd0, m_iv});
    chk("model_mul_A", mul_A, m_A);
    chk("model_mul_B", mul_B, m_B);
    chk("model_dst_tag", {27'd0, mul_dst_tag}, {27'd0, m_tag});
    chk("model_dst", {27'd0, mul_dst}, {27'd0, m_dst});
    chk("model_wr_en", {31'd0, mul_wr_en}, {31'd0, m_we});
    chk("model_full", {31'd0, full}, {31'd0, m_full});
  endtask

  task automatic chk_out(input string n, input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg, input logic [4:0] ds, input logic we, input logic fl);
    chk({n, "_iv"}, {31'd0, issue_valid}, {31'd0, iv});
    chk({n, "_A"}, mul_A, a);
    chk({n, "_B"}, mul_B, b);
    chk({n, "_tag"}, {27'd0, mul_dst_tag}, {27'd0, tg});
    chk({n, "_dst"}, {27'd0, mul_dst}, {27'd0, ds});
    chk({n, "_we"}, {31'd0, mul_wr_en}, {31'd0, we});
    chk({n, "_full"}, {31'd0, full}, {31'd0, fl});
  endtask

  typedef struct {
    logic dv; logic [31:0] vj; logic [4:0] qj; logic rj;
    logic [31:0] vk; logic [4:0] qk; logic rk;
    logic [4:0] tag; logic [4:0] dst; logic we;
    logic cv; logic [4:0] ctag; logic [31:0] cdata;
    logic e_iv; logic [31:0] e_A; logic [31:0] e_B;
    logic [4:0] e_tag; logic [4:0] e_dst; logic e_we; logic e_full;
  } vec_t;

  function automatic vec_t mkv(logic dv, logic [31:0] vj, logic [4:0] qj, logic rj,
                               logic [31:0] vk, logic [4:0] qk, logic rk,
                               logic [4:0] tag, logic [4:0] dst, logic we,
                               logic cv, logic [4:0] ctag, logic [31:0] cdata,
                               logic e_iv, logic [31:0] e_A, logic [31:0] e_B,
                               logic [4:0] e_tag, logic [4:0] e_dst, logic e_we, logic e_full);
    vec_t v;
    v.dv = dv; v.vj = vj; v.qj = qj; v.rj = rj; v.vk = vk; v.qk = qk; v.rk = rk;
    v.tag = tag; v.dst = dst; v.we = we; v.cv = cv; v.ctag = ctag; v.cdata = cdata;
    v.e_iv = e_iv; v.e_A = e_A; v.e_B = e_B; v.e_tag = e_tag; v.e_dst = e_dst;
    v.e_we = e_we; v.e_full = e_full;
    return v;
  endfunction

  initial begin
    vec_t vt [14];
    int n_iss, saw_ignored;

    // each row: inputs before an edge, outputs expected just after it
    vt[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mkv(1, 7, 0, 1, 6, 0, 1, 3, 9, 1,  0, 0, 0,      0, 0, 0, 0, 0, 0, 0);
    vt[2]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      1, 7, 6, 3, 9, 1, 0);
    vt[3]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mkv(1, 0, 5, 0, 4, 0, 1, 1, 2, 1,  0, 0, 0,      0, 0, 0, 0, 0, 0, 0);
    vt[5]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0, 0, 0, 0, 0);
    vt[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 6, 32'h99, 0, 0, 0, 0, 0, 0, 0);
    vt[7]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0, 0, 0, 0, 0);
    vt[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 5, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    vt[9]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      1, 32'h10, 4, 1, 2, 1, 0);
    vt[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0, 0, 0, 0, 0);
    vt[11] = mkv(1, 0, 2, 0, 3, 0, 1, 4, 5, 0,  1, 2, 11,     0, 0, 0, 0, 0, 0, 0);
    vt[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      1, 11, 3, 4, 5, 0, 0);
    vt[13] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0, 0, 0, 0, 0);

    // reset and idle
    idle();
    reset = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1;
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_out("idle", 0, 0, 0, 0, 0, 0, 0);

    // directed table: ready dispatch, CDB wakeup, wrong-tag broadcast, bypass
    for (int r = 0; r < 14; r++) begin
      idle();
      if (vt[r].dv) disp(vt[r].vj, vt[r].qj, vt[r].rj, vt[r].vk, vt[r].qk, vt[r].rk,
                         vt[r].tag, vt[r].dst, vt[r].we);
      if (vt[r].cv) cdb(vt[r].ctag, vt[r].cdata);
      tick();
      chk_out($sformatf("vec%0d", r), vt[r].e_iv, vt[r].e_A, vt[r].e_B,
              vt[r].e_tag, vt[r].e_dst, vt[r].e_we, vt[r].e_full);
    end

    // fill with non-ready entries; a fifth dispatch while full is ignored
    for (int i = 0; i < D; i++) begin
      idle();
      disp(0, 5'(10 + i), 0, 32'(100 + i), 0, 1, 5'(20 + i), 5'(i), 1);
      tick();
    end
    chk("full_after_fill", {31'd0, full}, 32'd1);
    idle();
    disp(55, 0, 1, 66, 0, 1, 30, 30, 1);
    tick();
    chk("full_ignored_disp_iv", {31'd0, issue_valid}, 32'd0);
    chk("full_still_set", {31'd0, full}, 32'd1);
    n_iss = 0; saw_ignored = 0;
    for (int t = 0; t < D + 4; t++) begin
      idle();
      if (t < D) cdb(5'(10 + t), 32'(200 + t));
      tick();
      if (issue_valid) begin
        n_iss++;
        if (mul_dst_tag == 5'd30) saw_ignored = 1;
      end
    end
    chk("full_drain_issues", 32'(n_iss), 32'd4);
    chk("full_ignored_never_issued", 32'(saw_ignored), 32'd0);
    chk("full_drained", {31'd0, full}, 32'd0);

    // priority: slots 0 and 2 wake on the same tag
    idle(); disp(0, 7, 0, 1, 0, 1, 21, 1, 1); tick();
    idle(); disp(0, 8, 0, 2, 0, 1, 22, 2, 1); tick();
    idle(); disp(0, 7, 0, 3, 0, 1, 23, 3, 1); tick();
    idle(); cdb(7, 32'h77); tick();
    chk("prio_capture_no_issue", {31'd0, issue_valid}, 32'd0);
    idle(); tick();
    chk_out("prio_first", 1, 32'h77, 1, 21, 1, 1, 0);
    idle(); tick();
    chk_out("prio_second", 1, 32'h77, 3, 23, 3, 1, 0);
    idle(); cdb(8, 32'h88); tick();
    idle(); tick();
    chk_out("prio_third", 1, 32'h88, 2, 22, 2, 1, 0);
    idle(); tick();

    // both operands captured on one broadcast
    idle(); disp(0, 9, 0, 0, 9, 0, 12, 13, 0); tick();
    idle(); cdb(9, 32'hABCD); tick();
    idle(); tick();
    chk_out("both_ops", 1, 32'hABCD, 32'hABCD, 12, 13, 0, 0);
    idle(); tick();

    // flush with busy entries and a pending issue
    for (int i = 0; i < 3; i++) begin
      idle(); disp(0, 15, 0, 1, 0, 1, 5'(i + 1), 5'(i), 1); tick();
    end
    idle(); disp(5, 0, 1, 6, 0, 1, 9, 9, 1); tick();
    chk("flush_pre_full", {31'd0, full}, 32'd1);
    idle(); flush = 1; tick();
    chk_out("flush", 0, 0, 0, 0, 0, 0, 0);
    idle(); cdb(15, 32'h55); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); tick();
      chk("flush_no_issue", {31'd0, issue_valid}, 32'd0);
    end

    // asynchronous reset between edges
    idle(); disp(3, 0, 1, 4, 0, 1, 17, 17, 1); tick();
    idle(); tick();
    chk("async_pre_iv", {31'd0, issue_valid}, 32'd1);
    #2;
    reset = 0;
    #1;
    chk("async_iv", {31'd0, issue_valid}, 32'd0);
    chk("async_we", {31'd0, mul_wr_en}, 32'd0);
    chk("async_A", mul_A, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1;
    idle(); tick();

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 99) < 45)
        disp($urandom, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
             $urandom, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
             5'($urandom), 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 99) < 50) cdb(5'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 99) < 2) flush = 1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
